// File: rtl/cobs_decode.sv
// Receive-side COBS decoder: 0x00-delimited encoded bytes in, decoded AXI-Stream frames out.
// A one-byte hold register delays each decoded byte so tlast can ride on the final byte.
module cobs_decode #(
  parameter int unsigned MAX_FRAME_BYTES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       frame_error
);

  localparam int unsigned CW = $clog2(MAX_FRAME_BYTES + 1);

  typedef enum logic [1:0] {IDLE, DATA, CODE, DISCARD} state_e;

  state_e        state_q, state_d;
  logic [7:0]    remaining_q, remaining_d;
  logic          zero_owed_q, zero_owed_d;
  logic [CW-1:0] dec_count_q, dec_count_d;
  logic          hold_valid_q, hold_valid_d;
  logic [7:0]    hold_data_q, hold_data_d;
  logic [7:0]    m_tdata_q, m_tdata_d;
  logic          m_tvalid_q, m_tvalid_d;
  logic          m_tlast_q, m_tlast_d;
  logic          m_tuser_q, m_tuser_d;
  logic          frame_error_q, frame_error_d;

  logic          accept;
  logic          has_x;
  logic [7:0]    x_data;
  logic          close;
  logic          close_err;
  logic          unused_tlast;

  assign unused_tlast  = s_axis_tlast;
  assign s_axis_tready = !rst && (!m_tvalid_q || m_axis_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_comb begin
    // NOTE: every next-state value defaults to its register first, so no branch can infer a latch.
    state_d       = state_q;
    remaining_d   = remaining_q;
    zero_owed_d   = zero_owed_q;
    dec_count_d   = dec_count_q;
    hold_valid_d  = hold_valid_q;
    hold_data_d   = hold_data_q;
    m_tdata_d     = m_tdata_q;
    m_tvalid_d    = m_tvalid_q && !m_axis_tready;
    m_tlast_d     = m_tlast_q;
    m_tuser_d     = m_tuser_q;
    frame_error_d = 1'b0;
    has_x         = 1'b0;
    x_data        = 8'h00;
    close         = 1'b0;
    close_err     = 1'b0;

    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (s_axis_tdata != 8'h00) begin
            remaining_d = s_axis_tdata - 8'd1;
            zero_owed_d = (s_axis_tdata != 8'hFF);
            state_d     = (s_axis_tdata == 8'h01) ? CODE : DATA;
            dec_count_d = '0;
          end
        end
        DATA: begin
          if (s_axis_tdata == 8'h00) begin
            close     = 1'b1;
            close_err = 1'b1;
            state_d   = IDLE;
          end else begin
            has_x       = 1'b1;
            x_data      = s_axis_tdata;
            remaining_d = remaining_q - 8'd1;
            if (remaining_q == 8'd1) state_d = CODE;
          end
        end
        CODE: begin
          if (s_axis_tdata == 8'h00) begin
            close   = 1'b1;
            state_d = IDLE;
          end else begin
            has_x       = zero_owed_q;
            x_data      = 8'h00;
            remaining_d = s_axis_tdata - 8'd1;
            zero_owed_d = (s_axis_tdata != 8'hFF);
            state_d     = (s_axis_tdata == 8'h01) ? CODE : DATA;
          end
        end
        DISCARD: begin
          if (s_axis_tdata == 8'h00) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      // One byte past the limit turns into an error close; the byte itself is thrown away.
      if (has_x) begin
        if (dec_count_q == CW'(MAX_FRAME_BYTES)) begin
          has_x     = 1'b0;
          close     = 1'b1;
          close_err = 1'b1;
          state_d   = DISCARD;
        end else begin
          dec_count_d = dec_count_q + CW'(1);
        end
      end

      if (has_x) begin
        if (hold_valid_q) begin
          m_tdata_d  = hold_data_q;
          m_tvalid_d = 1'b1;
          m_tlast_d  = 1'b0;
          m_tuser_d  = 1'b0;
        end
        hold_data_d  = x_data;
        hold_valid_d = 1'b1;
      end

      if (close) begin
        if (hold_valid_q) begin
          m_tdata_d  = hold_data_q;
          m_tvalid_d = 1'b1;
          m_tlast_d  = 1'b1;
          m_tuser_d  = close_err;
        end
        hold_valid_d  = 1'b0;
        frame_error_d = close_err;
      end
    end
  end

  // NOTE: state registers take non-blocking assignments only; reset is synchronous and active-high here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      remaining_q   <= '0;
      zero_owed_q   <= 1'b0;
      dec_count_q   <= '0;
      hold_valid_q  <= 1'b0;
      hold_data_q   <= '0;
      m_tdata_q     <= '0;
      m_tvalid_q    <= 1'b0;
      m_tlast_q     <= 1'b0;
      m_tuser_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      zero_owed_q   <= zero_owed_d;
      dec_count_q   <= dec_count_d;
      hold_valid_q  <= hold_valid_d;
      hold_data_q   <= hold_data_d;
      m_tdata_q     <= m_tdata_d;
      m_tvalid_q    <= m_tvalid_d;
      m_tlast_q     <= m_tlast_d;
      m_tuser_q     <= m_tuser_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tuser  = m_tuser_q;
  assign frame_error   = frame_error_q;

endmodule
